// File: rtl/pdm_playback.sv
// Voice playback transmitter: reads packed 8-bit PCM words from the sample RAM and
// re-modulates each sample into a 1-bit PDM stream with a first-order sigma-delta.
module pdm_playback #(
  parameter int unsigned sample_w        = 8,
  parameter int unsigned CLK_DIV         = 42,
  parameter int unsigned BITS_PER_SAMPLE = 240,
  parameter int unsigned WORDS           = 2830,
  parameter int unsigned addr_w          = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  ram_rd,
  output logic [addr_w-1:0]     ram_addr,
  input  logic [4*sample_w-1:0] ram_data,
  output logic                  pdm_out,
  output logic                  aud_en,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned WordBits = 4 * sample_w;
  localparam int unsigned DivW     = $clog2(CLK_DIV);
  localparam int unsigned BitW     = $clog2(BITS_PER_SAMPLE + 1);
  localparam int unsigned WordW    = $clog2(WORDS + 1);

  localparam logic [DivW-1:0]   DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0]   BitLast  = BitW'(BITS_PER_SAMPLE - 1);
  localparam logic [WordW-1:0]  WordLast = WordW'(WORDS - 1);
  localparam logic [addr_w-1:0] AddrLast = addr_w'(WORDS - 1);
  localparam logic [WordW:0]    WordsExt = (WordW + 1)'(WORDS);

  typedef enum logic [1:0] {StIdle, StFetch, StLoad, StPlay} state_e;

  state_e                state_q, state_d;
  logic [sample_w-1:0]   acc_q, acc_d;
  logic                  pdm_q, pdm_d;
  logic                  done_q, done_d;
  logic [addr_w-1:0]     addr_q, addr_d;
  logic [WordBits-1:0]   sh_q, sh_d;
  logic [WordBits-1:0]   buf_q, buf_d;
  logic                  pf_pend_q, pf_pend_d;
  logic [DivW-1:0]       div_q, div_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [1:0]            samp_q, samp_d;
  logic [WordW-1:0]      word_q, word_d;

  logic                  rd;
  logic [sample_w:0]     sum;
  logic [addr_w-1:0]     addr_inc;
  logic [WordW:0]        word_p2;
  logic                  more_reads;

  assign sum        = {1'b0, acc_q} + {1'b0, sh_q[WordBits-1 -: sample_w]};
  assign addr_inc   = (addr_q == AddrLast) ? addr_q : addr_q + 1'b1;
  // A prefetch is due only while a word beyond the next one still exists.
  assign word_p2    = {1'b0, word_q} + (WordW + 1)'(2);
  assign more_reads = word_p2 < WordsExt;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    pdm_d     = pdm_q;
    done_d    = 1'b0;
    addr_d    = addr_q;
    sh_d      = sh_q;
    buf_d     = buf_q;
    pf_pend_d = 1'b0;
    div_d     = div_q;
    bit_d     = bit_q;
    samp_d    = samp_q;
    word_d    = word_q;
    rd        = 1'b0;

    if (pf_pend_q) buf_d = ram_data;

    unique case (state_q)
      StIdle: begin
        acc_d  = '0;
        pdm_d  = 1'b0;
        addr_d = '0;
        if (start) state_d = StFetch;
      end
      StFetch: begin
        rd      = 1'b1;
        addr_d  = addr_inc;
        state_d = StLoad;
      end
      StLoad: begin
        sh_d   = ram_data;
        div_d  = '0;
        bit_d  = '0;
        samp_d = '0;
        word_d = '0;
        if (WORDS > 1) begin
          rd        = 1'b1;
          pf_pend_d = 1'b1;
          addr_d    = addr_inc;
        end
        state_d = StPlay;
      end
      StPlay: begin
        if (done_q) begin
          state_d = StIdle;
          pdm_d   = 1'b0;
        end else begin
          div_d = (div_q == DivLast) ? '0 : div_q + 1'b1;
          if (div_q == DivLast) begin
            pdm_d = sum[sample_w];
            acc_d = sum[sample_w-1:0];
            if (bit_q == BitLast) begin
              bit_d = '0;
              if (samp_q == 2'd3) begin
                samp_d = '0;
                if (word_q == WordLast) begin
                  done_d = 1'b1;
                end else begin
                  sh_d   = buf_q;
                  word_d = word_q + 1'b1;
                  if (more_reads) begin
                    rd        = 1'b1;
                    pf_pend_d = 1'b1;
                    addr_d    = addr_inc;
                  end
                end
              end else begin
                sh_d   = sh_q << sample_w;
                samp_d = samp_q + 2'd1;
              end
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over everything, including a same-cycle start.
    if (stop) begin
      state_d   = StIdle;
      acc_d     = '0;
      pdm_d     = 1'b0;
      done_d    = 1'b0;
      addr_d    = '0;
      rd        = 1'b0;
      pf_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      pdm_q     <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      sh_q      <= '0;
      buf_q     <= '0;
      pf_pend_q <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      pdm_q     <= pdm_d;
      done_q    <= done_d;
      addr_q    <= addr_d;
      sh_q      <= sh_d;
      buf_q     <= buf_d;
      pf_pend_q <= pf_pend_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      samp_q    <= samp_d;
      word_q    <= word_d;
    end
  end

  assign ram_rd   = rd;
  assign ram_addr = addr_q;
  assign pdm_out  = pdm_q;
  assign busy     = (state_q != StIdle);
  assign aud_en   = busy;
  assign done     = done_q;

endmodule

// File: tb/tb_pdm_playback.sv
// Randomized bench for pdm_playback: a cycle-indexed playback model derived from the
// sigma-delta arithmetic and the fixed timeline is checked against the DUT every cycle.
module tb_pdm_playback;

  localparam int unsigned SW  = 8;
  localparam int unsigned CD  = 2;
  localparam int unsigned BPS = 8;
  localparam int unsigned NW  = 3;
  localparam int unsigned AW  = 12;
  localparam int NT = NW * 4 * BPS;
  localparam int T  = 3 + NT * CD;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_data = '0;
  logic          pdm_out, aud_en, busy, done;

  pdm_playback #(
    .sample_w(SW), .CLK_DIV(CD), .BITS_PER_SAMPLE(BPS), .WORDS(NW), .addr_w(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
    .pdm_out(pdm_out), .aud_en(aud_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NW];

  always @(posedge clk) begin
    if (ram_rd) begin
      if (int'(ram_addr) < int'(NW)) ram_data <= mem[int'(ram_addr)];
      else ram_data <= 32'hDEAD_BEEF;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected PDM bit per tick, straight from the accumulate-and-carry rule.
  bit exp_bits [NT];
  function automatic void compute_bits();
    int acc = 0;
    for (int t = 0; t < NT; t++) begin
      int w = t / int'(4 * BPS);
      int i = (t / int'(BPS)) % 4;
      int b = int'((mem[w] >> (24 - 8 * i)) & 32'hFF);
      acc = acc + b;
      exp_bits[t] = (acc >= 256);
      acc = acc % 256;
    end
  endfunction

  // Read strobe schedule relative to the start cycle.
  function automatic bit exp_rd_at(input int k, output int a);
    a = 0;
    if (k == 1) begin a = 0; return 1'b1; end
    if (k == 2 && NW > 1) begin a = 1; return 1'b1; end
    for (int w = 0; w + 2 < int'(NW); w++)
      if (k == 3 + int'(4 * BPS) * (w + 1) * int'(CD) - 1) begin a = w + 2; return 1'b1; end
    return 1'b0;
  endfunction

  int cyc = 0;
  int s_cyc = 0;
  bit active = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) active <= 1'b0;
    else if (active) begin
      if (stop || (cyc - s_cyc) == T) active <= 1'b0;
    end else if (start && !stop) begin
      active <= 1'b1;
      s_cyc  <= cyc;
    end
  end

  bit chk_en = 1'b0;
  bit dut_bits [NT];
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_k = -1;
  int ck, cm, ca;
  bit ce_rd;

  always @(negedge clk) begin
    if (chk_en) begin
      if (ram_rd === 1'b1) rd_cnt++;
      if (active) begin
        ck = cyc - s_cyc;
        cm = (ck >= 3) ? (ck - 3) / int'(CD) : 0;
        if (done === 1'b1) begin done_cnt++; done_k = ck; end
        chk("busy", busy, 1);
        chk("aud_en", aud_en, 1);
        chk("done", done, (ck == T) ? 1 : 0);
        chk("pdm_out", pdm_out, (cm > 0 && cm <= NT) ? exp_bits[cm-1] : 0);
        if (ck >= 3 + int'(CD) && (ck - 3) % int'(CD) == 0 && cm <= NT)
          dut_bits[cm-1] = pdm_out;
        ce_rd = exp_rd_at(ck, ca);
        if (!stop) chk("ram_rd", ram_rd, ce_rd);
        if (ce_rd && !stop) chk("ram_addr", ram_addr, ca);
      end else begin
        if (done === 1'b1) done_cnt++;
        chk("idle_busy", busy, 0);
        chk("idle_aud_en", aud_en, 0);
        chk("idle_done", done, 0);
        chk("idle_pdm", pdm_out, 0);
        chk("idle_ram_rd", ram_rd, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) chk("wait_idle_timeout", n, 0);
    tick(2);
  endtask

  task automatic clr_stats();
    rd_cnt = 0; done_cnt = 0; done_k = -1;
  endtask

  task automatic rand_mem();
    for (int i = 0; i < int'(NW); i++) mem[i] = $urandom;
    compute_bits();
  endtask

  logic [15:0] ext_pat;
  int ones;
  int ak;

  initial begin
    for (int i = 0; i < int'(NW); i++) mem[i] = '0;
    compute_bits();

    rst = 1'b1;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clr_stats();
    tick(20);
    chk("reset_no_rd", rd_cnt, 0);

    // Mid-scale: 0x80 alternates 0,1 with half duty.
    mem[0] = 32'h8080_8080; mem[1] = $urandom; mem[2] = $urandom;
    compute_bits();
    ones = 0;
    for (int j = 0; j < 32; j++) ones += int'(exp_bits[j]);
    chk("model_mid_ones", ones, 16);
    chk("model_mid_b1", exp_bits[1], 1);
    clr_stats();
    pulse_start();
    wait_idle();
    ones = 0;
    for (int j = 0; j < 32; j++) ones += int'(dut_bits[j]);
    chk("mid_ones", ones, 16);
    for (int j = 0; j < 8; j++) chk("mid_pattern", dut_bits[j], j % 2);
    chk("mid_done_k", done_k, 195);
    chk("mid_done_cnt", done_cnt, 1);
    chk("mid_rd_cnt", rd_cnt, 3);

    // Extremes: 0xFF gives 0 then seven 1s; 0x00 afterwards adds no carries.
    mem[0] = 32'hFF00_FF00;
    compute_bits();
    ext_pat = 16'b0111_1111_0000_0000;
    for (int j = 0; j < 16; j++) chk("model_ext", exp_bits[j], ext_pat[15-j]);
    clr_stats();
    pulse_start();
    wait_idle();
    for (int j = 0; j < 16; j++) chk("ext_pattern", dut_bits[j], ext_pat[15-j]);

    // Full random utterance.
    rand_mem();
    clr_stats();
    pulse_start();
    wait_idle();
    chk("full_done_k", done_k, 195);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_rd_cnt", rd_cnt, 3);

    // Abort at cycle 40, then restart cleanly.
    clr_stats();
    pulse_start();
    tick(39);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_pdm", pdm_out, 0);
    tick(5);
    chk("abort_no_done", done_cnt, 0);
    clr_stats();
    pulse_start();
    wait_idle();
    chk("restart_done_k", done_k, 195);
    chk("restart_rd_cnt", rd_cnt, 3);

    // Start while busy is ignored.
    clr_stats();
    pulse_start();
    tick(20);
    start = 1'b1; tick(1); start = 1'b0;
    tick(80);
    start = 1'b1; tick(1); start = 1'b0;
    wait_idle();
    chk("busy_start_done_k", done_k, 195);
    chk("busy_start_done_cnt", done_cnt, 1);

    // Simultaneous start+stop in idle stays idle.
    clr_stats();
    start = 1'b1; stop = 1'b1; tick(1);
    start = 1'b0; stop = 1'b0; tick(1);
    chk("startstop_busy", busy, 0);
    tick(3);
    chk("startstop_no_rd", rd_cnt, 0);

    // Reset mid-playback.
    pulse_start();
    tick(30);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_pdm", pdm_out, 0);
    clr_stats();
    pulse_start();
    wait_idle();
    chk("post_rst_done_k", done_k, 195);

    // Randomized runs with occasional aborts.
    for (int r = 0; r < 8; r++) begin
      rand_mem();
      clr_stats();
      pulse_start();
      if ($urandom_range(1, 0) == 1) begin
        ak = $urandom_range(190, 3);
        tick(ak - 1);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(4);
        chk("rand_abort_no_done", done_cnt, 0);
      end else begin
        wait_idle();
        chk("rand_done_k", done_k, 195);
        chk("rand_rd_cnt", rd_cnt, 3);
      end
    end

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
